// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT datapath: frame geometry,
// complex-word field offsets and a bit-reversal helper.
package fft_pkg;
  localparam int FFT_N  = 32;
  localparam int CPLX_W = 64;

  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  // Reverse the low `bits` bits of v (bits = log2 N, at most 8).
  function automatic logic [7:0] bitrev(input logic [7:0] v, input int bits);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i < bits) r[3'(i)] = v[3'(bits - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// One N x W frame buffer: single write port, whole-frame flat read-out.
module fft_frame_bank #(
  parameter int N = 32,
  parameter int W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] lane,
  input  logic [W-1:0]         data,
  output logic [N*W-1:0]       frame
);
  logic [N-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (reset)   mem <= '0;
    else if (we) mem[lane] <= data;
  end

  assign frame = mem;
endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-frame loader for the twiddle column stage: collects N complex
// beats into a flat frame, ping-ponging between two banks.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int W      = CPLX_W,
  parameter int BITREV = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  input  logic           s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*W-1:0] m_frame,
  output logic           err_len
);
  localparam int LW = $clog2(N);

  logic                wr_bank, rd_bank;
  logic [1:0]          full, full_nx;
  logic [LW-1:0]       wr_idx, lane;
  logic                accept, at_end, commit, early, rel;
  logic [1:0][N*W-1:0] frames;

  assign s_ready = !full[wr_bank];
  assign accept  = s_valid & s_ready;
  assign at_end  = (wr_idx == LW'(N - 1));
  assign commit  = accept & at_end;
  assign early   = accept & s_last & !at_end;
  assign rel     = m_valid & m_ready;

  assign lane    = (BITREV != 0) ? LW'(bitrev(8'(wr_idx), LW)) : wr_idx;

  assign m_valid = full[rd_bank];
  assign m_frame = frames[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N), .W(W)) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (accept && (wr_bank == 1'(b))),
      .lane  (lane),
      .data  (s_data),
      .frame (frames[b])
    );
  end

  // Commit and release never target the same bank: commit needs it empty,
  // release needs it full.
  always_comb begin
    full_nx = full;
    if (rel)    full_nx[rd_bank] = 1'b0;
    if (commit) full_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      wr_idx  <= '0;
      err_len <= 1'b0;
    end else begin
      full    <= full_nx;
      // An early s_last discards the partial frame in place.
      if (accept) wr_idx <= early ? '0 : wr_idx + 1'b1;
      if (commit) wr_bank <= ~wr_bank;
      if (rel)    rd_bank <= ~rd_bank;
      err_len <= accept & (at_end ? !s_last : s_last);
    end
  end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench: a linear and a bit-reversed loader share one stimulus
// stream; a frame-level model predicts frames, handshakes and length errors.
module tb_fft_frame_loader;
  localparam int N = 32;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [W-1:0]   s_data = '0;
  logic           s_ready0, s_ready1, m_valid0, m_valid1, err0, err1;
  logic [N*W-1:0] m_frame0, m_frame1;

  fft_frame_loader #(.N(N), .W(W), .BITREV(0)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready),
    .m_frame(m_frame0), .err_len(err0));

  fft_frame_loader #(.N(N), .W(W), .BITREV(1)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready),
    .m_frame(m_frame1), .err_len(err1));

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] smp;    // samples in arrival order
    int             stamp;  // cycle at which the frame becomes visible
  } frm_t;

  frm_t           exp_q[$];
  int             err_q[$];
  logic [N*W-1:0] cur = '0;
  int             cur_n = 0;
  int             cyc = 0;
  int             checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rev5(input int k);
    int r = 0;
    for (int i = 0; i < 5; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Frame rules: N beats make a frame (error if the last lacks s_last);
  // s_last earlier discards the partial frame and flags an error.
  task automatic model_accept(input logic [W-1:0] d, input logic l);
    cur[cur_n*W +: W] = d;
    cur_n++;
    if (cur_n == N) begin
      exp_q.push_back('{smp: cur, stamp: cyc + 1});
      if (!l) err_q.push_back(cyc + 1);
      cur_n = 0;
      cur = '0;
    end else if (l) begin
      err_q.push_back(cyc + 1);
      cur_n = 0;
      cur = '0;
    end
  endtask

  always @(negedge clk) begin
    int committed;
    logic ev, ee;
    int bad0, bad1, j0, j1;
    if (!reset) begin
      committed = 0;
      foreach (exp_q[i]) if (exp_q[i].stamp <= cyc) committed++;
      ev = (committed > 0);
      ee = (err_q.size() > 0) && (err_q[0] <= cyc);
      chk("m_valid", 64'(m_valid0), 64'(ev));
      chk("m_valid_br", 64'(m_valid1), 64'(ev));
      chk("s_ready", 64'(s_ready0), 64'(committed < 2));
      chk("s_ready_br", 64'(s_ready1), 64'(committed < 2));
      chk("err_len", 64'(err0), 64'(ee));
      chk("err_len_br", 64'(err1), 64'(ee));
      if (ee) void'(err_q.pop_front());
      if (ev) begin
        bad0 = -1; bad1 = -1;
        for (int j = 0; j < N; j++) begin
          if (bad0 < 0 && m_frame0[j*W +: W] !== exp_q[0].smp[j*W +: W]) bad0 = j;
          if (bad1 < 0 && m_frame1[j*W +: W] !== exp_q[0].smp[rev5(j)*W +: W]) bad1 = j;
        end
        j0 = (bad0 < 0) ? 0 : bad0;
        j1 = (bad1 < 0) ? 0 : bad1;
        chk($sformatf("frame lane %0d", j0), m_frame0[j0*W +: W], exp_q[0].smp[j0*W +: W]);
        chk($sformatf("frame_br lane %0d", j1), m_frame1[j1*W +: W], exp_q[0].smp[rev5(j1)*W +: W]);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic l,
                       input logic mr, output logic acc);
    @(posedge clk); #1;
    s_valid = v; s_data = d; s_last = l; m_ready = mr;
    acc = v & s_ready0;
    if (acc) model_accept(d, l);
  endtask

  task automatic idle(input logic mr);
    logic acc;
    drive(1'b0, 64'(longint'($urandom) << 32 | longint'($urandom)), 1'($urandom), mr, acc);
  endtask

  task automatic send(input int n, input int last_at, input logic mr,
                      input logic mr_last, input bit pat);
    logic acc;
    logic [W-1:0] d;
    int tries;
    for (int k = 0; k < n; k++) begin
      d = pat ? {32'(k), ~32'(k)} : {$urandom, $urandom};
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 100) begin
        drive(1'b1, d, k == last_at, (k == n - 1) ? mr_last : mr, acc);
        tries++;
      end
      if (!acc) begin
        chk("accept timeout", 64'(acc), 64'd1);
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    exp_q.delete(); err_q.delete(); cur_n = 0; cur = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst m_valid", 64'(m_valid0), 64'd0);
    chk("rst s_ready", 64'(s_ready0), 64'd1);
    chk("rst err_len", 64'(err0), 64'd0);
    chk("rst m_frame", 64'(|m_frame0), 64'd0);
    chk("rst m_frame_br", 64'(|m_frame1), 64'd0);
  endtask

  initial begin
    logic acc;
    logic v, l;
    do_reset();

    // single frame with recognisable samples
    send(N, N - 1, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    chk("latency m_valid", 64'(m_valid0), 64'd1);
    chk("lane5", m_frame0[5*W +: W], 64'h00000005FFFFFFFA);
    chk("br lane16", m_frame1[16*W +: W], 64'h00000001FFFFFFFE);
    chk("br lane12", m_frame1[12*W +: W], 64'h00000006FFFFFFF9);
    chk("br lane0", m_frame1[0 +: W], 64'h00000000FFFFFFFF);
    chk("br lane31", m_frame1[31*W +: W], 64'h0000001FFFFFFFE0);
    repeat (3) idle(1'b1);

    // backpressure: two frames fill both banks
    send(N, N - 1, 1'b0, 1'b0, 1'b0);
    send(N, N - 1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("bp s_ready low", 64'(s_ready0), 64'd0);
    idle(1'b1);
    idle(1'b0);
    chk("bp s_ready high", 64'(s_ready0), 64'd1);
    send(N, N - 1, 1'b0, 1'b0, 1'b0);
    repeat (5) idle(1'b1);

    // early s_last on beat 9, then a clean frame
    send(10, 9, 1'b1, 1'b1, 1'b0);
    send(N, N - 1, 1'b1, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    // missing s_last
    send(N, -1, 1'b1, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // release coincides with the next commit
    send(N, N - 1, 1'b0, 1'b0, 1'b0);
    send(N, N - 1, 1'b0, 1'b1, 1'b0);
    repeat (4) idle(1'b1);

    // reset with one frame held and a partial fill
    send(N, N - 1, 1'b0, 1'b0, 1'b0);
    send(20, -1, 1'b0, 1'b0, 1'b0);
    do_reset();
    send(N, N - 1, 1'b1, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // random traffic with occasional length errors
    repeat (1500) begin
      v = ($urandom % 10) < 7;
      l = (cur_n == N - 1) ? 1'(($urandom % 16) != 0) : 1'(($urandom % 60) == 0);
      drive(v, {$urandom, $urandom}, l, 1'($urandom % 2), acc);
    end
    repeat (6) idle(1'b1);
    chk("frames drained", 64'(exp_q.size()), 64'd0);
    chk("errors seen", 64'(err_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
